// File: rtl/blur_window_controller.sv
// rtl/blur_window_controller.sv - line-buffer sequencer feeding 3x3 windows to the box-blur kernel
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a frame when idle
//   s_pixel     input pixel, raster order
//   s_valid     s_pixel valid
//   s_ready     pixel accepted this cycle when s_valid is also high
//   m_window    registered 3x3 window, byte k = 3*r + c (r = 0 oldest line, c = 0 leftmost column)
//   m_valid     registered window strobe to the kernel
//   line_free   one-cycle pulse, a line buffer is released (asserted while the last column of a row is issued)
//   frame_done  one-cycle pulse, the cycle after the last window of the frame
//   busy        high from the accepted start until the frame_done cycle inclusive
module blur_window_controller #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9 * PIXEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PIXEL_WIDTH-1:0]  s_pixel,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [WINDOW_WIDTH-1:0] m_window,
    output logic                    m_valid,
    output logic                    line_free,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);

    localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(IMAGE_WIDTH - 3);
    localparam logic [ROW_W-1:0] LINES_MAX   = ROW_W'(IMAGE_HEIGHT);
    localparam logic [ROW_W-1:0] ROWS_MAX    = ROW_W'(IMAGE_HEIGHT - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       wr_sel;
    logic [COL_W-1:0] wr_col;
    logic [1:0]       rd_sel;
    logic [COL_W-1:0] rd_col;
    logic [2:0]       avail;
    logic [2:0]       avail_next;
    logic [ROW_W-1:0] lines_in;
    logic [ROW_W-1:0] rows_out;
    logic [ROW_W-1:0] rows_out_inc;

    logic wr_en;
    logic wr_last;
    logic issue;
    logic rd_last;

    // Four rotating line buffers; contents are not reset.
    logic [PIXEL_WIDTH-1:0] line_mem [4][IMAGE_WIDTH];

    logic [1:0]              rd_line [3];
    logic [WINDOW_WIDTH-1:0] win_next;

    assign s_ready = ((state == ST_FILL) || (state == ST_RUN))
                     && (avail < 3'd4) && (lines_in < LINES_MAX);
    assign wr_en   = s_valid && s_ready;
    assign wr_last = wr_en && (wr_col == LAST_WR_COL);
    assign issue   = (state == ST_RUN);
    assign rd_last = issue && (rd_col == LAST_RD_COL);

    assign line_free    = rd_last;
    assign rows_out_inc = rows_out + ROW_W'(1);

    // A line completing and a row releasing in the same cycle cancel out.
    assign avail_next = avail + {2'b00, wr_last} - {2'b00, rd_last};

    always_comb begin
        rd_line[0] = rd_sel;
        rd_line[1] = rd_sel + 2'd1;
        rd_line[2] = rd_sel + 2'd2;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_sel][wr_col] <= s_pixel;
        end
    end

    // The window register doubles as the column shift register: mid-row only
    // the rightmost column is fetched and the other two shift left. The first
    // window of a row has no usable history, so all three columns are read.
    always_comb begin
        win_next = m_window;
        for (int r = 0; r < 3; r++) begin
            if (rd_col == '0) begin
                for (int c = 0; c < 3; c++) begin
                    win_next[(3*r+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = line_mem[rd_line[r]][COL_W'(c)];
                end
            end else begin
                win_next[(3*r)*PIXEL_WIDTH +: PIXEL_WIDTH]   = m_window[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
                win_next[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH] = m_window[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH];
                win_next[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH] = line_mem[rd_line[r]][rd_col + COL_W'(2)];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (avail >= 3'd3) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_last) begin
                    if (rows_out_inc == ROWS_MAX) begin
                        state_next = ST_DONE;
                    end else if (avail_next >= 3'd3) begin
                        // Stay in RUN so windows continue back-to-back across rows.
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_sel     <= '0;
            wr_col     <= '0;
            rd_sel     <= '0;
            rd_col     <= '0;
            avail      <= '0;
            lines_in   <= '0;
            rows_out   <= '0;
            m_window   <= '0;
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            m_valid    <= issue;
            frame_done <= (state == ST_DONE);

            if (issue) begin
                m_window <= win_next;
            end

            if ((state == ST_IDLE) && start) begin
                busy <= 1'b1;
            end else if (frame_done) begin
                busy <= 1'b0;
            end

            if (state == ST_DONE) begin
                // Lines still buffered beyond the last output row are discarded.
                wr_sel   <= '0;
                wr_col   <= '0;
                rd_sel   <= '0;
                rd_col   <= '0;
                avail    <= '0;
                lines_in <= '0;
                rows_out <= '0;
            end else begin
                if (wr_en) begin
                    if (wr_col == LAST_WR_COL) begin
                        wr_col   <= '0;
                        wr_sel   <= wr_sel + 2'd1;
                        lines_in <= lines_in + ROW_W'(1);
                    end else begin
                        wr_col <= wr_col + COL_W'(1);
                    end
                end
                if (issue) begin
                    if (rd_last) begin
                        rd_col   <= '0;
                        rd_sel   <= rd_sel + 2'd1;
                        rows_out <= rows_out_inc;
                    end else begin
                        rd_col <= rd_col + COL_W'(1);
                    end
                end
                avail <= avail_next;
            end
        end
    end

endmodule

// File: tb/tb_blur_window_controller.sv
// tb/tb_blur_window_controller.sv - scoreboard bench for blur_window_controller
module tb_blur_window_controller;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic [71:0] m_window;
    logic        m_valid;
    logic        line_free;
    logic        frame_done;
    logic        busy;

    blur_window_controller #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .PIXEL_WIDTH  (8),
        .WINDOW_WIDTH (72)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_pixel    (s_pixel),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_window   (m_window),
        .m_valid    (m_valid),
        .line_free  (line_free),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    logic [71:0] exp_q [$];
    logic [71:0] exp_w;
    logic [71:0] first_win;
    int  win_cnt     = 0;
    int  lf_cnt      = 0;
    int  fd_cnt      = 0;
    int  last_mv_cyc = 0;
    int  fd_cyc      = 0;
    int  lat_edge    = 0;
    bit  lat_pending = 0;
    bit  abort       = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_window(input int base, input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(3*r+c)*8 +: 8] = 8'(base + (r0 + r) * W + c0 + c);
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int base);
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                exp_q.push_back(exp_window(base, r, c));
            end
        end
    endtask

    // Monitor: pops the scoreboard on every presented window.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (m_valid) begin
                if (lat_pending) begin
                    lat_pending = 0;
                    first_win   = m_window;
                    chk_i("first_window_latency", cyc, lat_edge + 2);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_window: got %h with no window expected", m_window);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk_w("window", m_window, exp_w);
                end
                win_cnt++;
                last_mv_cyc = cyc;
            end
            if (line_free) lf_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_px(input logic [7:0] v, output bit ok, output int edge_idx);
        int t;
        t        = 0;
        ok       = 1;
        edge_idx = 0;
        s_pixel  = v;
        s_valid  = 1'b1;
        while (!s_ready && !abort && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (abort) begin
            ok      = 0;
            s_valid = 1'b0;
            return;
        end
        if (t >= 500) begin
            ok = 0;
            checks++;
            errs++;
            $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles expected acceptance", t);
            s_valid = 1'b0;
            return;
        end
        edge_idx = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send_frame(input int base, input bit gaps);
        bit ok;
        int e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && ((r * W + c) % 3 == 2)) begin
                    s_valid = 1'b0;
                    repeat (2) @(negedge clk);
                end
                send_px(8'(base + r * W + c), ok, e);
                if (!ok) return;
                if (r == 2 && c == W - 1) lat_edge = e;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_i("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_frame(input int base, input bit gaps, input bit poke_start);
        int wb, lb, fb, t;
        wb = win_cnt;
        lb = lf_cnt;
        fb = fd_cnt;
        push_frame(base);
        lat_pending = 1;
        do_start();
        fork
            send_frame(base, gaps);
            begin
                if (poke_start) begin
                    repeat (30) @(negedge clk);
                    chk_i("busy_mid_frame", int'(busy), 1);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        t = 0;
        while (fd_cnt == fb && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        chk_i("window_count", win_cnt - wb, NWIN);
        chk_i("line_free_count", lf_cnt - lb, H - 2);
        chk_i("frame_done_count", fd_cnt - fb, 1);
        chk_i("frame_done_after_last_window", fd_cyc, last_mv_cyc + 1);
        chk_i("scoreboard_drained", exp_q.size(), 0);
        chk_i("busy_after_done", int'(busy), 0);
        chk_i("s_ready_after_done", int'(s_ready), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_i({tag, "_m_valid"}, int'(m_valid), 0);
        chk_w({tag, "_m_window"}, m_window, 72'd0);
        chk_i({tag, "_s_ready"}, int'(s_ready), 0);
        chk_i({tag, "_line_free"}, int'(line_free), 0);
        chk_i({tag, "_frame_done"}, int'(frame_done), 0);
        chk_i({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int sum;
        int wb;
        int t;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_pixel = 8'd0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: continuous stream, pixel = row*8+col.
        run_frame(0, 1'b0, 1'b0);
        sum = 0;
        for (int k = 0; k < 9; k++) sum += int'(first_win[k*8 +: 8]);
        chk_i("kernel_first_output", sum / 9, 9);

        // Frame 2: bursty input plus an ignored start mid-frame.
        run_frame(100, 1'b1, 1'b1);

        // Frame 3: asynchronous reset mid-run, between clock edges.
        wb = win_cnt;
        push_frame(50);
        lat_pending = 1;
        do_start();
        fork
            send_frame(50, 1'b0);
            begin
                t = 0;
                while (win_cnt - wb < 8 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                chk_i("windows_before_reset", int'(win_cnt - wb >= 8), 1);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                abort = 1;
                #1;
                chk_outputs_zero("async_reset");
            end
        join
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        lat_pending = 0;
        abort = 0;
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 4: full frame after reset, pixel values wrap through 255.
        run_frame(230, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1);
    end

endmodule

// File: doc/blur_window_controller.md
Name: blur_window_controller

Overview:
- Sequencer that sits in front of the 3x3 box-blur kernel.
- Accepts a raster pixel stream into four rotating line buffers and schedules 3x3 window reads, one per cycle.
- Drives the kernel's 72-bit window input and its valid strobe.
- Reports line-buffer release and frame completion so the upstream DMA/host can pace input.

Parameters:
- IMAGE_WIDTH, 512, pixels per line (>=4).
- IMAGE_HEIGHT, 512, lines per frame (>=3).
- PIXEL_WIDTH, 8, bits per pixel.
- WINDOW_WIDTH, 72, 9*PIXEL_WIDTH, width of window bus to kernel.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- s_pixel  in  PIXEL_WIDTH  input pixel, raster order.
- s_valid  in  1  s_pixel valid.
- s_ready  out  1  controller accepts s_pixel this cycle.
- m_window  out  WINDOW_WIDTH  3x3 window to kernel pixelInput.
- m_valid  out  1  window valid, drives kernel pixelInput_valid.
- line_free  out  1  one-cycle pulse; one line buffer released.
- frame_done  out  1  one-cycle pulse; last window of frame issued.
- busy  out  1  high from accepted start until frame_done cycle inclusive.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous active-low. While rst_n is low, all outputs are 0, the FSM is IDLE, and all counters are 0. Reset mid-frame abandons the frame with no completion pulse. Line-buffer RAM contents are don't-care.
- Transfers: accepted when s_valid && s_ready. The pixel is written to buffer wr_sel at column wr_col.
  - wr_col wraps at IMAGE_WIDTH-1. On wrap, wr_sel increments mod 4, avail increments, and lines_in increments.
- s_ready = (state is FILL or RUN) && avail < 4 && lines_in < IMAGE_HEIGHT.
- FSM states: IDLE, FILL, RUN, DONE.
  - IDLE: start moves to FILL, and busy rises the next cycle. start in any other state is ignored.
  - FILL: waits until avail >= 3, then moves to RUN.
  - RUN: issues one window per cycle, rd_col = 0 .. IMAGE_WIDTH-3, i.e. IMAGE_WIDTH-2 windows per output row. Edge windows are not produced (no padding).
  - End of row (last column issued): rd_sel increments mod 4, avail decrements, line_free pulses, and rows_out increments. Then:
    - if rows_out reaches IMAGE_HEIGHT-2, go to DONE;
    - else if avail_next >= 3, stay in RUN, so m_valid stays continuous across rows;
    - otherwise go to FILL.
  - DONE: frame_done pulses for one cycle, then IDLE. avail, lines_in, wr/rd pointers and counters are cleared, and the remaining buffered lines are discarded.
- avail_next: a write-line completion and a row release in the same cycle leave avail unchanged. avail never exceeds 4 or underflows.
- Window packing: byte k = 3*r + c occupies bits [8k+7:8k].
  - r = 0 is the oldest line (rd_sel), r = 2 is the newest (rd_sel+2 mod 4).
  - c = 0 is column rd_col, c = 2 is column rd_col+2.
- Latency: m_window and m_valid are registered. The first m_valid asserts exactly 2 cycles after the edge that accepts the last pixel of line 3. Each later window follows at 1 per cycle while in RUN.
- Kernel has no back-pressure, so m_valid is never stalled mid-row. RAM reads must sustain 3 columns x 3 lines per cycle, using column shift registers.
- The write buffer never equals any buffer being read, because avail < 4 gates writes.

Test Plan:
- Fill and first window (W=8, H=6): reset, start, stream pixel value = row*8+col with s_valid constant. First m_valid comes 2 cycles after pixel (2,7) is accepted. The first window bytes are 0,1,2,8,9,10,16,17,18, and the kernel outputs 9.
- Full frame, same image: exactly 24 windows in 4 rows of 6, 4 line_free pulses, and 1 frame_done on the cycle after the last m_valid. busy then falls and s_ready stays 0.
- Back-pressure: hold s_valid high continuously. s_ready drops once avail = 4 and reasserts the cycle after the first line_free. No pixel is lost or duplicated, and all window values match the reference model.
- Simultaneous events: align a line completion with a row release. avail is unchanged and RUN continues with no m_valid gap between rows.
- Start while busy: pulse start mid-frame. There is no effect, and the window count stays at 24.
- Async reset mid-RUN: drop rst_n between clock edges. All outputs are 0 immediately. A new start then produces a correct full frame.
